// File: rtl/fpsqrt_issue_pkg.sv
// Shared FSM state type, rounding-mode and format codes, and LFSR taps
// for the square-root issue controller.
package fpsqrt_issue_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      BP    = 3'd3,
      RESP  = 3'd4
   } state_t;

   localparam logic [2:0] RM_RNE = 3'd0;
   localparam logic [2:0] RM_RTZ = 3'd1;
   localparam logic [2:0] RM_RDN = 3'd2;
   localparam logic [2:0] RM_RUP = 3'd3;
   localparam logic [2:0] RM_RMM = 3'd4;

   localparam logic [1:0] FMT_FP32 = 2'd0;
   localparam logic [1:0] FMT_FP64 = 2'd1;
   localparam logic [1:0] FMT_FP16 = 2'd2;

   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/fpsqrt_issue_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used to randomise finish back-pressure.
module fpsqrt_issue_lfsr
   import fpsqrt_issue_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] state
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SEED;
      end else begin
         state <= {state[14:0], ^(state & LFSR_TAPS)};
      end
   end

endmodule

// File: rtl/fpsqrt_issue_ctrl.sv
// Issue controller for a single-outstanding square-root unit: captures a
// request, starts the unit, applies randomised finish back-pressure, returns
// the response, and aborts via flush when the unit stalls too long.
module fpsqrt_issue_ctrl
   import fpsqrt_issue_pkg::*;
#(
   parameter int unsigned TAG_W       = 8,
   parameter int unsigned TIMEOUT_CYC = 256,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [63:0]      req_op_i,
   input  logic [1:0]       req_fp_format_i,
   input  logic [2:0]       req_rm_i,
   input  logic             req_vector_mode_i,
   input  logic [TAG_W-1:0] req_tag_i,
   output logic             start_valid_o,
   input  logic             start_ready_i,
   output logic [63:0]      op_o,
   output logic [1:0]       fp_format_o,
   output logic [2:0]       rm_o,
   output logic             vector_mode_o,
   output logic             flush_o,
   input  logic             finish_valid_i,
   output logic             finish_ready_o,
   input  logic [63:0]      fpsqrt_res_i,
   input  logic [4:0]       fflags_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [63:0]      rsp_res_o,
   output logic [4:0]       rsp_fflags_o,
   output logic [TAG_W-1:0] rsp_tag_o,
   output logic             rsp_timeout_o,
   input  logic [3:0]       bp_mask_i,
   output logic             busy_o,
   output logic [31:0]      done_cnt_o
);

   localparam int unsigned   TO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   state_t           state, state_next;
   logic [15:0]      lfsr;
   logic             unused_lfsr_hi;
   logic [63:0]      op_q;
   logic [1:0]       fmt_q;
   logic [2:0]       rm_q;
   logic             vm_q;
   logic [TAG_W-1:0] tag_q;
   logic [63:0]      res_q;
   logic [4:0]       fflags_q;
   logic             timeout_q;
   logic [31:0]      done_cnt;
   logic [3:0]       bp_cnt;
   logic [TO_W-1:0]  to_cnt;
   logic             timeout_hit;
   logic             accept, bp_load, finish_fire, rsp_fire;

   fpsqrt_issue_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .state (lfsr)
   );

   assign unused_lfsr_hi = ^lfsr[15:4];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next     = state;
      req_ready_o    = 1'b0;
      start_valid_o  = 1'b0;
      finish_ready_o = 1'b0;
      rsp_valid_o    = 1'b0;
      flush_o        = 1'b0;
      accept         = 1'b0;
      bp_load        = 1'b0;
      finish_fire    = 1'b0;
      rsp_fire       = 1'b0;
      timeout_hit    = (to_cnt == TO_LAST);
      case (state)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               accept     = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            start_valid_o = 1'b1;
            if (timeout_hit) begin
               flush_o    = 1'b1;
               state_next = RESP;
            end else if (start_ready_i) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            // A finish arriving on the timeout cycle takes priority over the flush.
            if (finish_valid_i) begin
               bp_load    = 1'b1;
               state_next = BP;
            end else if (timeout_hit) begin
               flush_o    = 1'b1;
               state_next = RESP;
            end
         end
         BP: begin
            finish_ready_o = (bp_cnt == 4'd0);
            if (finish_valid_i && (bp_cnt == 4'd0)) begin
               finish_fire = 1'b1;
               state_next  = RESP;
            end
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) begin
               rsp_fire   = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= '0;
         fmt_q     <= '0;
         rm_q      <= '0;
         vm_q      <= 1'b0;
         tag_q     <= '0;
         res_q     <= '0;
         fflags_q  <= '0;
         timeout_q <= 1'b0;
         done_cnt  <= '0;
         bp_cnt    <= '0;
         to_cnt    <= '0;
      end else begin
         if (accept) begin
            op_q   <= req_op_i;
            fmt_q  <= req_fp_format_i;
            rm_q   <= req_rm_i;
            vm_q   <= req_vector_mode_i;
            tag_q  <= req_tag_i;
            to_cnt <= '0;
         end else if ((state == ISSUE) || (state == WAIT)) begin
            to_cnt <= to_cnt + TO_W'(1);
         end
         if (bp_load) begin
            bp_cnt <= lfsr[3:0] & bp_mask_i;
         end else if ((state == BP) && (bp_cnt != 4'd0)) begin
            bp_cnt <= bp_cnt - 4'd1;
         end
         if (finish_fire) begin
            res_q     <= fpsqrt_res_i;
            fflags_q  <= fflags_i;
            timeout_q <= 1'b0;
         end else if (flush_o) begin
            res_q     <= '0;
            fflags_q  <= '0;
            timeout_q <= 1'b1;
         end
         if (rsp_fire) begin
            done_cnt <= done_cnt + 32'd1;
         end
      end
   end

   assign op_o          = op_q;
   assign fp_format_o   = fmt_q;
   assign rm_o          = rm_q;
   assign vector_mode_o = vm_q;
   assign rsp_res_o     = res_q;
   assign rsp_fflags_o  = fflags_q;
   assign rsp_tag_o     = tag_q;
   assign rsp_timeout_o = timeout_q;
   assign busy_o        = (state != IDLE);
   assign done_cnt_o    = done_cnt;

endmodule

// File: tb/tb_fpsqrt_issue_ctrl.sv
// Scoreboard bench for fpsqrt_issue_ctrl: a behavioural sqrt unit and response
// sink drive the DUT while a monitor checks every handshake against queues.
module tb_fpsqrt_issue_ctrl;
   import fpsqrt_issue_pkg::*;

   localparam int unsigned TAG_W  = 8;
   localparam int unsigned TO_CYC = 16;

   typedef struct packed {
      logic [63:0] res;
      logic [4:0]  ff;
      logic [7:0]  tag;
      logic        to;
   } rsp_t;

   typedef struct packed {
      logic [63:0] op;
      logic [1:0]  fmt;
      logic [2:0]  rm;
      logic        vm;
   } start_t;

   localparam logic [63:0] TBL_OP  [4] = '{64'h4010_0000_0000_0000, 64'h3FF0_0000_0000_0000,
                                           64'h4030_0000_0000_0000, 64'h4000_0000_0000_0000};
   localparam logic [63:0] TBL_RES [4] = '{64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000,
                                           64'h4010_0000_0000_0000, 64'h3FF6_A09E_667F_3BCD};
   localparam logic [4:0]  TBL_FF  [4] = '{5'h00, 5'h00, 5'h00, 5'h01};

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req_valid_i, req_ready_o;
   logic [63:0]      req_op_i;
   logic [1:0]       req_fp_format_i;
   logic [2:0]       req_rm_i;
   logic             req_vector_mode_i;
   logic [TAG_W-1:0] req_tag_i;
   logic             start_valid_o, start_ready_i;
   logic [63:0]      op_o;
   logic [1:0]       fp_format_o;
   logic [2:0]       rm_o;
   logic             vector_mode_o, flush_o;
   logic             finish_valid_i, finish_ready_o;
   logic [63:0]      fpsqrt_res_i;
   logic [4:0]       fflags_i;
   logic             rsp_valid_o, rsp_ready_i;
   logic [63:0]      rsp_res_o;
   logic [4:0]       rsp_fflags_o;
   logic [TAG_W-1:0] rsp_tag_o;
   logic             rsp_timeout_o;
   logic [3:0]       bp_mask_i;
   logic             busy_o;
   logic [31:0]      done_cnt_o;

   fpsqrt_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT_CYC(TO_CYC), .LFSR_SEED(16'hACE1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
      .req_fp_format_i(req_fp_format_i), .req_rm_i(req_rm_i),
      .req_vector_mode_i(req_vector_mode_i), .req_tag_i(req_tag_i),
      .start_valid_o(start_valid_o), .start_ready_i(start_ready_i), .op_o(op_o),
      .fp_format_o(fp_format_o), .rm_o(rm_o), .vector_mode_o(vector_mode_o),
      .flush_o(flush_o),
      .finish_valid_i(finish_valid_i), .finish_ready_o(finish_ready_o),
      .fpsqrt_res_i(fpsqrt_res_i), .fflags_i(fflags_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_res_o(rsp_res_o),
      .rsp_fflags_o(rsp_fflags_o), .rsp_tag_o(rsp_tag_o), .rsp_timeout_o(rsp_timeout_o),
      .bp_mask_i(bp_mask_i), .busy_o(busy_o), .done_cnt_o(done_cnt_o)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0;
   logic [15:0] tb_lfsr;
   rsp_t        rsp_q[$];
   start_t      start_q[$];

   int          start_stall = 0;
   int          fin_delay = 10;
   int          rsp_hold = 0;
   bit          never_finish = 1'b0;

   int          rsp_count = 0;
   int          start_fires = 0;
   int          last_sv_len = 0;
   int          flush_count = 0;
   int unsigned flush_edge = 0;
   int unsigned accept_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference LFSR stepping in lockstep with the DUT to predict back-pressure.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tb_lfsr <= 16'hACE1;
      else        tb_lfsr <= {tb_lfsr[14:0], tb_lfsr[15] ^ tb_lfsr[13] ^ tb_lfsr[12] ^ tb_lfsr[10]};
   end

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic void sqrt_model(input logic [63:0] op, output logic [63:0] res,
                                      output logic [4:0] ff);
      res = '1;
      ff  = 5'h10;
      for (int unsigned k = 0; k < 4; k++) begin
         if (op == TBL_OP[k]) begin
            res = TBL_RES[k];
            ff  = TBL_FF[k];
         end
      end
   endfunction

   initial begin : sqrt_unit
      bit          st_fire, fn_fire, fl, m_busy;
      int          m_cnt, stall_left;
      logic [63:0] m_op;
      start_ready_i = 1'b0; finish_valid_i = 1'b0; fpsqrt_res_i = '0; fflags_i = '0;
      m_busy = 1'b0; m_cnt = 0; stall_left = 0; m_op = '0;
      forever begin
         @(negedge clk);
         st_fire = rst_n && start_valid_o && start_ready_i;
         fn_fire = rst_n && finish_valid_i && finish_ready_o;
         fl      = rst_n && flush_o;
         if (st_fire) m_op = op_o;
         @(posedge clk); #1;
         if (!rst_n || fl) begin
            m_busy = 1'b0; finish_valid_i = 1'b0;
         end else if (st_fire) begin
            m_busy = 1'b1; m_cnt = fin_delay - 1;
         end else if (fn_fire) begin
            m_busy = 1'b0; finish_valid_i = 1'b0;
         end else if (m_busy && !finish_valid_i && !never_finish) begin
            if (m_cnt <= 0) begin
               finish_valid_i = 1'b1;
               sqrt_model(m_op, fpsqrt_res_i, fflags_i);
            end else begin
               m_cnt--;
            end
         end
         if (rst_n && start_valid_o) begin
            if (stall_left > 0) begin start_ready_i = 1'b0; stall_left--; end
            else start_ready_i = 1'b1;
         end else begin
            start_ready_i = 1'b0; stall_left = start_stall;
         end
      end
   end

   initial begin : rsp_sink
      int hold_left;
      hold_left = 0;
      rsp_ready_i = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (rsp_valid_o) begin
            if (hold_left > 0) begin rsp_ready_i = 1'b0; hold_left--; end
            else rsp_ready_i = 1'b1;
         end else begin
            rsp_ready_i = 1'b0; hold_left = rsp_hold;
         end
      end
   end

   initial begin : monitor
      rsp_t        got, held, e_rsp;
      start_t      e_st;
      logic        prev_rv, prev_rr, prev_sv, prev_sr, prev_fv, prev_ff;
      logic [63:0] prev_op;
      int unsigned fv_start;
      int          exp_lat, lat, sv_run;
      prev_rv = 0; prev_rr = 0; prev_sv = 0; prev_sr = 0; prev_fv = 0; prev_ff = 0;
      prev_op = '0; fv_start = 0; exp_lat = 1; lat = 0; sv_run = 0; held = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_rv = 0; prev_rr = 0; prev_sv = 0; prev_sr = 0; prev_fv = 0; prev_ff = 0;
            continue;
         end
         got = {rsp_res_o, rsp_fflags_o, rsp_tag_o, rsp_timeout_o};
         if (prev_ff) check("rsp_latency", rsp_valid_o, 1'b1);
         if (rsp_valid_o && prev_rv && !prev_rr) check("rsp_stable", got, held);
         if (rsp_valid_o && rsp_ready_i) begin
            if (rsp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL rsp_unexpected: got %h expected no response", got);
            end else begin
               e_rsp = rsp_q.pop_front();
               check("rsp_res", rsp_res_o, e_rsp.res);
               check("rsp_fflags", rsp_fflags_o, e_rsp.ff);
               check("rsp_tag", rsp_tag_o, e_rsp.tag);
               check("rsp_timeout", rsp_timeout_o, e_rsp.to);
               rsp_count++;
            end
         end
         held = got; prev_rv = rsp_valid_o; prev_rr = rsp_ready_i;

         if (start_valid_o && prev_sv && !prev_sr) check("start_op_stable", op_o, prev_op);
         sv_run = start_valid_o ? (prev_sv ? sv_run + 1 : 1) : 0;
         if (start_valid_o && start_ready_i) begin
            start_fires++;
            last_sv_len = sv_run;
            if (start_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL start_unexpected: got op %h expected no start", op_o);
            end else begin
               e_st = start_q.pop_front();
               check("start_fields", {op_o, fp_format_o, rm_o, vector_mode_o},
                     {e_st.op, e_st.fmt, e_st.rm, e_st.vm});
            end
         end
         prev_op = op_o; prev_sv = start_valid_o; prev_sr = start_ready_i;

         if (finish_valid_i && !prev_fv) begin
            fv_start = cyc;
            exp_lat  = int'(tb_lfsr[3:0] & bp_mask_i) + 1;
         end
         prev_ff = finish_valid_i && finish_ready_o;
         if (prev_ff) begin
            lat = int'(cyc - fv_start);
            check("bp_latency", lat, exp_lat);
            check("bp_latency_range", (lat >= 1 && lat <= 16), 1'b1);
         end
         prev_fv = finish_valid_i;

         if (flush_o) begin
            flush_count++;
            flush_edge = cyc + 1;
         end
      end
   end

   task automatic send_req(input logic [63:0] op, input logic [1:0] fmt, input logic [2:0] rm,
                           input logic vm, input logic [7:0] tag, input rsp_t e_rsp);
      int n;
      n = 0;
      @(posedge clk); #1;
      while (!req_ready_o && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready_o) begin
         checks++; failures++;
         $display("FAIL req_ready_wait: req_ready_o=0 after %0d cycles expected 1", n);
         return;
      end
      req_valid_i = 1'b1; req_op_i = op; req_fp_format_i = fmt; req_rm_i = rm;
      req_vector_mode_i = vm; req_tag_i = tag;
      rsp_q.push_back(e_rsp);
      start_q.push_back('{op: op, fmt: fmt, rm: rm, vm: vm});
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      accept_cyc = cyc;
      check("start_latency", start_valid_o, 1'b1);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy_o || rsp_q.size() != 0) && n < budget);
      if (busy_o || rsp_q.size() != 0) begin
         checks++; failures++;
         $display("FAIL %s: busy=%b pending=%0d after %0d cycles expected idle", name, busy_o,
                  rsp_q.size(), budget);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_ctl"}, {req_ready_o, start_valid_o, finish_ready_o, rsp_valid_o, flush_o,
                             rsp_timeout_o, busy_o}, 7'b1000000);
      check({name, "_done_cnt"}, done_cnt_o, 32'd0);
      check({name, "_rsp_data"}, {rsp_res_o, rsp_fflags_o, rsp_tag_o}, '0);
      check({name, "_start_data"}, {op_o, fp_format_o, rm_o, vector_mode_o}, '0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      rsp_q.delete();
      start_q.delete();
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached expected completion");
      $fatal(1);
   end

   initial begin : stim
      int fc0, rc0, sf0;
      req_valid_i = 1'b0; req_op_i = '0; req_fp_format_i = '0; req_rm_i = '0;
      req_vector_mode_i = 1'b0; req_tag_i = '0; bp_mask_i = 4'h0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Basic sqrt(4.0) with no back-pressure.
      fin_delay = 10;
      send_req(TBL_OP[0], FMT_FP64, RM_RNE, 1'b0, 8'h5A, '{res: TBL_RES[0], ff: 5'h00, tag: 8'h5A, to: 1'b0});
      wait_idle("basic_idle", 100);
      check("basic_done_cnt", done_cnt_o, 32'd1);

      // Start stalled for 5 cycles.
      sf0 = start_fires; start_stall = 5; fin_delay = 3;
      send_req(TBL_OP[1], FMT_FP32, RM_RTZ, 1'b1, 8'h11, '{res: TBL_RES[1], ff: 5'h00, tag: 8'h11, to: 1'b0});
      wait_idle("stall_idle", 100);
      check("stall_sv_cycles", last_sv_len, 6);
      check("stall_start_count", start_fires - sf0, 1);
      check("stall_done_cnt", done_cnt_o, 32'd2);
      start_stall = 0;

      // 32 back-to-back requests with full back-pressure mask.
      do_reset();
      bp_mask_i = 4'hF; fin_delay = 2; rc0 = rsp_count;
      for (int unsigned i = 0; i < 32; i++) begin
         send_req(TBL_OP[i % 4], FMT_FP64, 3'(i % 5), i[0], 8'(8'h80 + i),
                  '{res: TBL_RES[i % 4], ff: TBL_FF[i % 4], tag: 8'(8'h80 + i), to: 1'b0});
      end
      wait_idle("burst_idle", 200);
      check("burst_done_cnt", done_cnt_o, 32'd32);
      check("burst_rsp_count", rsp_count - rc0, 32);
      bp_mask_i = 4'h0;

      // Unit never finishes: timeout flush.
      do_reset();
      fc0 = flush_count; never_finish = 1'b1;
      send_req(TBL_OP[0], FMT_FP64, RM_RNE, 1'b0, 8'h32, '{res: 64'h0, ff: 5'h00, tag: 8'h32, to: 1'b1});
      wait_idle("timeout_idle", 100);
      never_finish = 1'b0;
      check("timeout_flush_count", flush_count - fc0, 1);
      check("timeout_flush_edge", flush_edge - accept_cyc, 16);

      // Finish lands exactly on the timeout cycle: finish wins.
      fc0 = flush_count; fin_delay = 14;
      send_req(TBL_OP[3], FMT_FP64, RM_RUP, 1'b0, 8'h33, '{res: TBL_RES[3], ff: 5'h01, tag: 8'h33, to: 1'b0});
      wait_idle("coincide_idle", 100);
      check("coincide_flush_count", flush_count - fc0, 0);

      // Response held off 7 cycles, then reset mid-WAIT.
      rsp_hold = 7; fin_delay = 2;
      send_req(TBL_OP[2], FMT_FP64, RM_RMM, 1'b1, 8'h34, '{res: TBL_RES[2], ff: 5'h00, tag: 8'h34, to: 1'b0});
      wait_idle("hold_idle", 100);
      rsp_hold = 0; fin_delay = 12;
      fc0 = flush_count; rc0 = rsp_count;
      send_req(TBL_OP[0], FMT_FP64, RM_RDN, 1'b0, 8'h35, '{res: TBL_RES[0], ff: 5'h00, tag: 8'h35, to: 1'b0});
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("mid_wait_state", {busy_o, start_valid_o, rsp_valid_o}, 3'b100);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("mid_reset");
      check("abandoned_pending", rsp_q.size(), 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      rsp_q.delete();
      start_q.delete();
      repeat (20) @(negedge clk);
      check_reset_outputs("post_reset");
      check("post_reset_no_rsp", rsp_count - rc0, 0);
      check("post_reset_no_flush", flush_count - fc0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fpsqrt_issue_ctrl.md
FPSQRT_ISSUE_CTRL -- requirements
Module: fpsqrt_issue_ctrl

Interface
REQ-001 SHALL have parameters: TAG_W, default 8, request tag width; TIMEOUT_CYC, default 256, maximum cycles spent in ISSUE plus WAIT; LFSR_SEED, default 16'hACE1, LFSR reset value.
REQ-002 SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Clock and reset ports: clk in 1, clock; rst_n in 1, asynchronous active-low reset.
REQ-004 Upstream request ports: req_valid_i in 1; req_ready_o out 1; req_op_i in 64; req_fp_format_i in 2; req_rm_i in 3; req_vector_mode_i in 1; req_tag_i in TAG_W.
REQ-005 Sqrt-unit start ports: start_valid_o out 1; start_ready_i in 1; op_o out 64; fp_format_o out 2; rm_o out 3; vector_mode_o out 1; flush_o out 1.
REQ-006 Sqrt-unit finish ports: finish_valid_i in 1; finish_ready_o out 1; fpsqrt_res_i in 64; fflags_i in 5.
REQ-007 Response ports: rsp_valid_o out 1; rsp_ready_i in 1; rsp_res_o out 64; rsp_fflags_o out 5; rsp_tag_o out TAG_W; rsp_timeout_o out 1.
REQ-008 Configuration and status ports: bp_mask_i in 4, finish-ready delay mask; busy_o out 1; done_cnt_o out 32, count of completed responses.

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, WAIT, BP and RESP, all registered.
REQ-010 req_ready_o SHALL equal (state==IDLE); on a request handshake, op, format, rm, vector_mode and tag SHALL be captured and the state SHALL go to ISSUE.
REQ-011 In ISSUE, start_valid_o=1 with the captured fields on op_o etc. SHALL be held stable until start_ready_i=1, then the state SHALL go to WAIT.
REQ-012 In WAIT, finish_ready_o=0; on finish_valid_i=1, bp_cnt SHALL load lfsr[3:0] & bp_mask_i and the state SHALL go to BP.
REQ-013 In BP, finish_ready_o SHALL equal (bp_cnt==0); bp_cnt SHALL decrement while nonzero.
REQ-014 In BP, on finish_valid_i & finish_ready_o, fpsqrt_res_i and fflags_i SHALL be captured, rsp_timeout SHALL be cleared, and the state SHALL go to RESP.
REQ-015 In RESP, rsp_valid_o=1 with the captured result, fflags and tag SHALL be held stable until rsp_ready_i=1; done_cnt_o SHALL then increment (wrapping at 2^32) and the state SHALL go to IDLE.
REQ-016 The 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle after reset.
REQ-017 The timeout counter SHALL clear on request acceptance and increment each cycle in ISSUE and WAIT.
REQ-018 When the timeout count reaches TIMEOUT_CYC-1, flush_o SHALL pulse high for exactly one cycle, rsp_res and rsp_fflags SHALL be set to 0, rsp_timeout_o SHALL be set to 1, and the state SHALL go to RESP.
REQ-019 Simultaneous finish_valid_i and timeout in WAIT: finish SHALL win and there SHALL be no flush.
REQ-020 The timeout SHALL NOT apply in BP or RESP.
REQ-021 Minimum latency SHALL be: request handshake -> start_valid_o in 1 cycle; finish_valid_i -> finish_ready_o in 1 cycle (mask=0); finish handshake -> rsp_valid_o in 1 cycle.
REQ-022 busy_o SHALL equal (state!=IDLE).
REQ-023 A start handshake and a finish handshake SHALL never occur in the same cycle; at most one operation SHALL be outstanding.

Reset
REQ-024 On rst_n low, the state SHALL go to IDLE and all valid, ready, flush and timeout outputs SHALL be 0, except req_ready_o, which SHALL be 1 after reset.
REQ-025 On rst_n low, data and tag registers, done_cnt_o, bp_cnt and the timeout counter SHALL be 0, and the LFSR SHALL be LFSR_SEED.
REQ-026 Reset mid-operation SHALL abandon the operation with no response and no flush; the sqrt unit is reset by the same rst_n.

Structure
REQ-027 Package fpsqrt_issue_pkg SHALL hold the state enum, the RM_RNE/RTZ/RDN/RUP/RMM constants, the FP16/FP32/FP64 format codes and the LFSR tap constant.
REQ-028 The LFSR SHALL be sub-module fpsqrt_issue_lfsr (seed parameter, 16-bit state output); everything else SHALL be inline.

Verification
REQ-029 Request op=64'h4010_0000_0000_0000, fmt=FP64, rm=RNE, tag=8'h5A, bp_mask=0, model finishes 10 cycles after start -> rsp_res=64'h4000_0000_0000_0000, tag 5A, timeout 0, done_cnt=1.
REQ-030 start_ready_i held low 5 cycles -> start_valid_o and op_o stable for all 6 cycles; one start handshake only.
REQ-031 bp_mask=4'hF, 32 back-to-back requests -> every finish_ready_o assertion is 1-16 cycles after finish_valid_i; results in order; done_cnt=32.
REQ-032 Model never asserts finish_valid_i, TIMEOUT_CYC=16 -> flush_o pulses once 16 cycles after acceptance; rsp_timeout_o=1, rsp_res=0.
REQ-033 finish_valid_i coincides with the timeout cycle -> no flush; real result returned; timeout 0.
REQ-034 rsp_ready_i low 7 cycles, then rst_n asserted mid-WAIT on the next request -> response held stable; after reset all outputs match REQ-024 and REQ-025 and req_ready_o=1.
